ns_msg_relay: RTL and testbench
===============================

# ns_msg_relay

Buffered single-clock relay for the codebase's 4-phase message channels (src/dst/dat/red + req/ack). It sits directly downstream of a test source or traffic generator and upstream of a checking sink. It accepts messages on input channel i0 and checks redundancy with `calc_redun`. Good messages go into a DEPTH-entry FIFO and are re-issued in order on output channel o0. The relay decouples producer and consumer handshake timing and counts corrupted messages.

## Interface
- ASZ, `NS_ADDRESS_SIZE, address field width (src, dst)
- DSZ, `NS_DATA_SIZE, data field width
- RSZ, `NS_REDUN_SIZE, redundancy field width
- DEPTH, 4, FIFO entries; power of two, 2..16
- REQ_CKS, `NS_REQ_CKS, consecutive stable cycles to accept an i0_req_in level
- ACK_CKS, `NS_ACK_CKS, consecutive stable cycles to accept an o0_ack_in level
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- i0_src / i0_dst  in  ASZ  input message addresses
- i0_dat  in  DSZ  input message data
- i0_red  in  RSZ  input message redundancy
- i0_req_in  in  1  input request (asynchronous to clk)
- i0_ack_out  out  1  input acknowledge
- o0_src / o0_dst  out  ASZ  output message addresses
- o0_dat  out  DSZ  output message data
- o0_red  out  RSZ  output message redundancy (forwarded unchanged)
- o0_req_out  out  1  output request
- o0_ack_in  in  1  output acknowledge (asynchronous to clk)
- level  out  clog2(DEPTH)+1  current FIFO occupancy
- err  out  1  sticky: at least one bad-redundancy message dropped
- err_cnt  out  8  dropped-message count, saturates at 255

## Operation
- Conditioning:
  - i0_req_in and o0_ack_in each pass through a 2-flop synchronizer, then a debouncer.
  - The debounced level (ckd_req / ckd_ack) takes the synchronized value only after it has held for REQ_CKS / ACK_CKS consecutive edges.
  - Any change of the synchronized value restarts that count.
- Input FSM:
  - IN_IDLE:
    - If ckd_req=1, i0_ack_out=0 and level<DEPTH:
      - Compare i0_red with calc_redun(i0_src, i0_dst, i0_dat).
      - Match: write {src, dst, dat, red} at the write pointer and increment the write pointer.
      - Mismatch: discard the message, set err=1, and increment err_cnt with saturation.
      - Either way, set i0_ack_out=1 and go to IN_ACK.
    - If level==DEPTH: stay in IN_IDLE with ack low (backpressure). Nothing is written and the message is not lost.
  - IN_ACK: when ckd_req=0, set i0_ack_out=0 and go to IN_IDLE.
- Output FSM:
  - OUT_IDLE: if level>0 and ckd_ack=0, load o0_* from the head entry, set o0_req_out=1, go to OUT_REQ.
  - OUT_REQ: when ckd_ack=1, set o0_req_out=0, advance the read pointer (pop), go to OUT_WAIT.
  - OUT_WAIT: when ckd_ack=0, go to OUT_IDLE.
- o0_* data fields are stable from the req rise until one clock after the pop.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- level updates on each clock:
  - +1 on a write without a pop.
  - -1 on a pop without a write.
  - Unchanged on a simultaneous write and pop.
- A dropped message never changes level.
- Order is preserved. No message is duplicated or reordered.

## Timing
- Reset (asynchronous assert, synchronous release):
  - Outputs: i0_ack_out=0, o0_req_out=0, o0_src=o0_dst=o0_dat=o0_red=0, level=0, err=0, err_cnt=0.
  - Internal: both FSMs idle, pointers 0, debounced levels 0, debounce counters 0.
- Reset mid-handshake drops req/ack immediately and discards all FIFO contents.
- i0_req_in rise to ckd_req rise: 2+REQ_CKS clocks. i0_ack_out rises 1 clock after ckd_req rises, if not full.
- The write at clock t makes level nonzero after t. If the output FSM is idle, o0_req_out rises at t+1 (1-clock cut-through).
- ckd_ack rise to o0_req_out fall and pop: 1 clock.
- When full, the pop clock frees a slot. A pending input is accepted on the next clock.
- The write is evaluated against level as registered at the clock edge. A same-clock pop does not allow a write into a full FIFO.
- Sustained throughput: one message per max(input cycle, output cycle). No bubbles are added beyond the handshake.

## Test plan
- Reset then idle, inputs quiet -> all outputs 0 and level=0 for 50 clocks.
- Single message src=0, dst=1, dat=5, valid red, sink acks promptly:
  - i0_ack_out rises 3+REQ_CKS clocks after req.
  - o0_req_out rises 1 clock later with identical fields.
  - level goes 0->1->0.
- Sink stalled (o0_ack_in=0 held high-free), 6 messages dat=0..5, DEPTH=4:
  - Exactly 4 are acked and level=4. Message 5 waits with no ack.
  - After the sink is released, dat=0..5 emerge in order and err=0.
- Message with i0_red XOR 1:
  - It is acked, but o0_req_out never rises and level stays 0.
  - err=1, err_cnt=1. A following valid message passes normally.
- 300 corrupted messages -> err_cnt saturates at 255 and err stays 1.
- Glitch and reset cases:
  - i0_req_in pulsed for REQ_CKS-1 clocks -> no ack, no write.
  - reset asserted while o0_req_out=1 with level=3 -> o0_req_out=0 and level=0 asynchronously; after release no stale message is emitted.

Source files
------------

// File: rtl/ns_msg_relay_if.sv
// ns_msg_relay_if: one 4-phase message channel.
// A channel carries the fields src/dst/dat/red plus the req/ack handshake pair.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 8
`endif

interface ns_msg_relay_if #(
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE
);
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;
    logic           req;
    logic           ack;

    modport master (output src, dst, dat, red, req, input ack);
    modport slave  (input src, dst, dat, red, req, output ack);
endinterface

// File: rtl/ns_msg_relay.sv
// ns_msg_relay: buffered relay between two 4-phase message channels.
// Incoming messages are redundancy-checked. Good ones are queued in a FIFO and
// re-issued in order. Bad ones are acknowledged, dropped and counted.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 8
`endif
`ifndef NS_REQ_CKS
`define NS_REQ_CKS 3
`endif
`ifndef NS_ACK_CKS
`define NS_ACK_CKS 2
`endif

module ns_msg_relay #(
    parameter int ASZ     = `NS_ADDRESS_SIZE,
    parameter int DSZ     = `NS_DATA_SIZE,
    parameter int RSZ     = `NS_REDUN_SIZE,
    parameter int DEPTH   = 4,
    parameter int REQ_CKS = `NS_REQ_CKS,
    parameter int ACK_CKS = `NS_ACK_CKS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ns_msg_relay_if.slave          i0,
    ns_msg_relay_if.master         o0,
    output logic [$clog2(DEPTH):0] level,
    output logic                   err,
    output logic [7:0]             err_cnt
);
    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = PW + 1;
    localparam int FW  = 2 * ASZ + DSZ;
    localparam int EW  = FW + RSZ;
    localparam int NCH = (FW + RSZ - 1) / RSZ;
    localparam int RCW = $clog2(REQ_CKS + 1);
    localparam int ACW = $clog2(ACK_CKS + 1);

    typedef enum logic {IN_IDLE, IN_ACK} in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_WAIT} out_state_t;

    // Redundancy is the XOR of all RSZ-wide chunks of {src, dst, dat}.
    // The top chunk is zero-padded when the field width does not divide evenly.
    function automatic logic [RSZ-1:0] calc_redun(input logic [ASZ-1:0] s,
                                                  input logic [ASZ-1:0] d,
                                                  input logic [DSZ-1:0] x);
        logic [NCH*RSZ-1:0] padded;
        logic [RSZ-1:0]     acc;
        padded         = '0;
        padded[FW-1:0] = {s, d, x};
        acc            = '0;
        for (int i = 0; i < NCH; i++) acc ^= padded[i*RSZ +: RSZ];
        return acc;
    endfunction

    logic            req_s1, req_s2, ack_s1, ack_s2;
    logic            ckd_req, ckd_ack;
    logic [RCW-1:0]  req_cnt;
    logic [ACW-1:0]  ack_cnt;
    in_state_t       in_state, in_next;
    out_state_t      out_state, out_next;
    logic            red_ok, wr_en, drop_en, load_en, pop_en;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   out_q;

    assign red_ok = (i0.red == calc_redun(i0.src, i0.dst, i0.dat));

    // Two-flop synchronizers for the asynchronous req and ack inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_s1 <= 1'b0;
            req_s2 <= 1'b0;
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
        end else begin
            req_s1 <= i0.req;
            req_s2 <= req_s1;
            ack_s1 <= o0.ack;
            ack_s2 <= ack_s1;
        end
    end

    // Req debouncer: adopt the synchronized level after REQ_CKS stable edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ckd_req <= 1'b0;
            req_cnt <= '0;
        end else if (req_s2 == ckd_req) begin
            req_cnt <= '0;
        end else if (req_cnt == RCW'(REQ_CKS - 1)) begin
            ckd_req <= req_s2;
            req_cnt <= '0;
        end else begin
            req_cnt <= req_cnt + 1'b1;
        end
    end

    // Ack debouncer: adopt the synchronized level after ACK_CKS stable edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ckd_ack <= 1'b0;
            ack_cnt <= '0;
        end else if (ack_s2 == ckd_ack) begin
            ack_cnt <= '0;
        end else if (ack_cnt == ACW'(ACK_CKS - 1)) begin
            ckd_ack <= ack_s2;
            ack_cnt <= '0;
        end else begin
            ack_cnt <= ack_cnt + 1'b1;
        end
    end

    // Input FSM: accept or drop a message when there is room, then wait for req to fall.
    always_comb begin
        in_next = in_state;
        wr_en   = 1'b0;
        drop_en = 1'b0;
        case (in_state)
            IN_IDLE: begin
                if (ckd_req && (level < LW'(DEPTH))) begin
                    wr_en   = red_ok;
                    drop_en = !red_ok;
                    in_next = IN_ACK;
                end
            end
            IN_ACK: begin
                if (!ckd_req) in_next = IN_IDLE;
            end
            default: in_next = IN_IDLE;
        endcase
    end

    // Output FSM: present the head entry, pop on ack, then wait for ack to fall.
    always_comb begin
        out_next = out_state;
        load_en  = 1'b0;
        pop_en   = 1'b0;
        case (out_state)
            OUT_IDLE: begin
                if ((level != '0) && !ckd_ack) begin
                    load_en  = 1'b1;
                    out_next = OUT_REQ;
                end
            end
            OUT_REQ: begin
                if (ckd_ack) begin
                    pop_en   = 1'b1;
                    out_next = OUT_WAIT;
                end
            end
            OUT_WAIT: begin
                if (!ckd_ack) out_next = OUT_IDLE;
            end
            default: out_next = OUT_IDLE;
        endcase
    end

    // State, pointers, occupancy, error tracking and the output field register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state  <= IN_IDLE;
            out_state <= OUT_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
            out_q     <= '0;
        end else begin
            in_state  <= in_next;
            out_state <= out_next;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop_en) begin
                err <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
            end
            if (load_en) out_q <= mem[rd_ptr];
        end
    end

    // FIFO storage; entries are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {i0.src, i0.dst, i0.dat, i0.red};
    end

    assign i0.ack = (in_state == IN_ACK);
    assign o0.req = (out_state == OUT_REQ);
    assign o0.src = out_q[EW-1 -: ASZ];
    assign o0.dst = out_q[EW-ASZ-1 -: ASZ];
    assign o0.dat = out_q[RSZ +: DSZ];
    assign o0.red = out_q[RSZ-1:0];
endmodule

// File: tb/tb_ns_msg_relay.sv
// tb_ns_msg_relay: randomized bench for ns_msg_relay.
// The reference is a queue of expected good messages plus a saturating drop count.
module tb_ns_msg_relay;
    localparam int ASZ     = 8;
    localparam int DSZ     = 16;
    localparam int RSZ     = 8;
    localparam int DEPTH   = 4;
    localparam int REQ_CKS = 3;
    localparam int ACK_CKS = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] level;
    logic       err;
    logic [7:0] err_cnt;

    ns_msg_relay_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) i0_bus ();
    ns_msg_relay_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) o0_bus ();

    ns_msg_relay #(
        .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .DEPTH(DEPTH),
        .REQ_CKS(REQ_CKS), .ACK_CKS(ACK_CKS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i0(i0_bus), .o0(o0_bus),
        .level(level), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [39:0] exp_q[$];
    logic [39:0] exp_word;
    int          model_err    = 0;
    int          acks_done    = 0;
    int          level_at_ack = 0;
    bit          sink_stall   = 1'b0;
    int          cyc          = 0;
    int          oreq_rises   = 0;
    int          iack_rises   = 0;
    int          last_oreq_cyc = 0;
    int          last_iack_cyc = 0;
    logic        oreq_prev    = 1'b0;
    logic        iack_prev    = 1'b0;

    // Counts one comparison and reports it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference redundancy for 8/8/16-bit fields: XOR of the four bytes.
    function automatic logic [7:0] ref_redun(input logic [7:0] s, input logic [7:0] d, input logic [15:0] x);
        return s ^ d ^ x[15:8] ^ x[7:0];
    endfunction

    function automatic logic [63:0] out_word();
        return {10'd0, i0_bus.ack, o0_bus.req, o0_bus.src, o0_bus.dst, o0_bus.dat,
                o0_bus.red, level, err, err_cnt};
    endfunction

    // Sends one message as a 4-phase producer and updates the reference model.
    task automatic applyStimulus(input logic [7:0] src, input logic [7:0] dst,
                                 input logic [15:0] dat, input bit corrupt, output int lat);
        logic [7:0] red;
        red = ref_redun(src, dst, dat) ^ (corrupt ? 8'h01 : 8'h00);
        if (!corrupt) exp_q.push_back({src, dst, dat, red});
        @(negedge clk);
        i0_bus.src = src;
        i0_bus.dst = dst;
        i0_bus.dat = dat;
        i0_bus.red = red;
        i0_bus.req = 1'b1;
        lat = -1;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (i0_bus.ack) begin
                lat = k;
                level_at_ack = int'(level);
                break;
            end
        end
        checkOutput("ack_seen", 64'(i0_bus.ack), 64'd1);
        if (lat > 0) begin
            acks_done++;
            if (corrupt && model_err < 255) model_err++;
        end
        i0_bus.req = 1'b0;
        for (int k = 0; k < 2000 && i0_bus.ack; k++) @(negedge clk);
        checkOutput("ack_release", 64'(i0_bus.ack), 64'd0);
    endtask

    // Waits (bounded) until every expected message has been issued and popped.
    task automatic waitDrain();
        for (int k = 0; k < 3000; k++) begin
            if (exp_q.size() == 0 && !o0_bus.req) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);
        checkOutput("level_drained", 64'(level), 64'd0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every o0 request must carry the next expected message.
    always @(negedge clk) begin
        if (!rst_n) begin
            oreq_prev <= 1'b0;
            iack_prev <= 1'b0;
        end else begin
            if (o0_bus.req && !oreq_prev) begin
                oreq_rises    <= oreq_rises + 1;
                last_oreq_cyc <= cyc;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_msg", 64'(o0_bus.dat), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_word = exp_q.pop_front();
                    checkOutput("o0_fields", 64'({o0_bus.src, o0_bus.dst, o0_bus.dat, o0_bus.red}),
                                64'(exp_word));
                end
            end
            if (i0_bus.ack && !iack_prev) begin
                iack_rises    <= iack_rises + 1;
                last_iack_cyc <= cyc;
            end
            oreq_prev <= o0_bus.req;
            iack_prev <= i0_bus.ack;
        end
    end

    // Sink: acknowledges each request after a short random delay unless stalled.
    initial begin
        o0_bus.ack = 1'b0;
        forever begin
            @(negedge clk);
            if (o0_bus.req && !sink_stall) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                o0_bus.ack = 1'b1;
                for (int k = 0; k < 500 && o0_bus.req; k++) @(negedge clk);
                checkOutput("sink_req_fall", 64'(o0_bus.req), 64'd0);
                o0_bus.ack = 1'b0;
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int r0;
        int a0;
        i0_bus.src = '0;
        i0_bus.dst = '0;
        i0_bus.dat = '0;
        i0_bus.red = '0;
        i0_bus.req = 1'b0;

        // Reset, then 50 quiet clocks.
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", out_word(), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checkOutput("idle_outputs", out_word(), 64'd0);
        end

        // Single message: latency and cut-through.
        $display("[TB] single message");
        applyStimulus(8'd0, 8'd1, 16'd5, 1'b0, lat);
        checkOutput("ack_latency", 64'(lat), 64'(3 + REQ_CKS));
        checkOutput("level_at_ack", 64'(level_at_ack), 64'd1);
        waitDrain();
        checkOutput("cut_through", 64'(last_oreq_cyc - last_iack_cyc), 64'd1);

        // Stalled sink: six messages into a four-entry FIFO.
        $display("[TB] stalled sink");
        sink_stall = 1'b1;
        acks_done  = 0;
        fork
            begin
                int ls;
                for (int d = 0; d < 6; d++)
                    applyStimulus(8'($urandom), 8'($urandom), 16'(d), 1'b0, ls);
            end
            begin
                repeat (150) @(negedge clk);
                checkOutput("stall_acks", 64'(acks_done), 64'd4);
                checkOutput("stall_level", 64'(level), 64'(DEPTH));
                checkOutput("stall_pending_ack", 64'(i0_bus.ack), 64'd0);
                sink_stall = 1'b0;
            end
        join
        waitDrain();
        checkOutput("stall_err", 64'(err), 64'd0);

        // One corrupted message followed by a good one.
        $display("[TB] corrupted message");
        r0 = oreq_rises;
        applyStimulus(8'($urandom), 8'($urandom), 16'($urandom), 1'b1, lat);
        repeat (20) @(negedge clk);
        checkOutput("bad_no_output", 64'(oreq_rises), 64'(r0));
        checkOutput("bad_level", 64'(level), 64'd0);
        checkOutput("bad_err", 64'(err), 64'd1);
        checkOutput("bad_err_cnt", 64'(err_cnt), 64'(model_err));
        applyStimulus(8'($urandom), 8'($urandom), 16'($urandom), 1'b0, lat);
        waitDrain();
        checkOutput("good_after_bad", 64'(oreq_rises), 64'(r0 + 1));

        // Random mix of good and corrupted messages.
        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++)
            applyStimulus(8'($urandom), 8'($urandom), 16'($urandom),
                          ($urandom_range(0, 4) == 0), lat);
        waitDrain();
        checkOutput("mix_err_cnt", 64'(err_cnt), 64'(model_err));

        // Drop counter saturation.
        $display("[TB] saturation");
        for (int i = 0; i < 300; i++)
            applyStimulus(8'($urandom), 8'($urandom), 16'($urandom), 1'b1, lat);
        repeat (5) @(negedge clk);
        checkOutput("sat_err_cnt", 64'(err_cnt), 64'(model_err));
        checkOutput("sat_err_cnt_max", 64'(err_cnt), 64'd255);
        checkOutput("sat_err", 64'(err), 64'd1);

        // Req glitch shorter than the debounce window.
        $display("[TB] req glitch");
        a0 = iack_rises;
        r0 = oreq_rises;
        @(negedge clk);
        i0_bus.src = 8'h12;
        i0_bus.dst = 8'h34;
        i0_bus.dat = 16'h5678;
        i0_bus.red = ref_redun(8'h12, 8'h34, 16'h5678);
        i0_bus.req = 1'b1;
        repeat (REQ_CKS - 1) @(negedge clk);
        i0_bus.req = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("glitch_no_ack", 64'(iack_rises), 64'(a0));
        checkOutput("glitch_level", 64'(level), 64'd0);
        checkOutput("glitch_no_output", 64'(oreq_rises), 64'(r0));

        // Reset while a request is outstanding with three entries queued.
        $display("[TB] reset mid-handshake");
        sink_stall = 1'b1;
        for (int i = 0; i < 3; i++)
            applyStimulus(8'($urandom), 8'($urandom), 16'($urandom), 1'b0, lat);
        repeat (5) @(negedge clk);
        checkOutput("pre_reset_level", 64'(level), 64'd3);
        checkOutput("pre_reset_req", 64'(o0_bus.req), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_req", 64'(o0_bus.req), 64'd0);
        checkOutput("async_reset_level", 64'(level), 64'd0);
        checkOutput("async_reset_err", 64'({err, err_cnt}), 64'd0);
        exp_q.delete();
        model_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        sink_stall = 1'b0;
        r0 = oreq_rises;
        repeat (40) @(negedge clk);
        checkOutput("no_stale_output", 64'(oreq_rises), 64'(r0));
        applyStimulus(8'hA5, 8'h5A, 16'hBEEF, 1'b0, lat);
        waitDrain();
        checkOutput("post_reset_msg", 64'(oreq_rises), 64'(r0 + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
